stack_pointer_unit: RTL
=======================

# stack_pointer_unit

Parametrised stack pointer for the core's memory stage. Replaces the fixed single-step SP register with a width/depth-configurable unit that executes multi-word push/pop bursts (e.g. PC+flags on CALL/INT) one word per cycle. It drives the per-word stack address to data memory and flags stack overflow and underflow. It sits between the control unit, which issues Change_SP/Control_Mux, and the data-memory address mux.

## Interface
- WIDTH, 32: SP and address width.
- SP_RESET, 32'h000FFFFF: SP value after reset; top of the empty stack.
- DEPTH, 1024: stack capacity in words.
- CNT_W, 2: width of Word_Count.
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Change_SP  input  1  operation request; sampled only in IDLE.
- Control_Mux  input  2  operation: 00 hold, 01 push, 10 pop, 11 load.
- Word_Count  input  CNT_W  words per push/pop; 0 is treated as 1.
- Load_Value  input  WIDTH  new SP value for load.
- Stall  input  1  pipeline freeze.
- Output_Signal  output  WIDTH  current SP.
- Mem_Addr  output  WIDTH  address of the current word transfer.
- Mem_Valid  output  1  a word transfer is presented this cycle.
- Mem_Write  output  1  1 = push (memory write), 0 = pop (memory read).
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle pulse after the last word of a burst.
- Overflow  output  1  sticky: a push was rejected.
- Underflow  output  1  sticky: a pop was rejected.

## Operation
- State machine has three states: IDLE, PUSH, POP. Registers: SP, state, remaining count, Done, Overflow, Underflow.
- Used words are computed as SP_RESET - SP, a WIDTH-bit unsigned difference.
- IDLE, Change_SP=1, Stall=0:
  - 00: no change.
  - 01 with n words: if used+n > DEPTH, the push is rejected. SP is unchanged, Overflow is set, and the unit stays in IDLE. Otherwise it goes to PUSH with remaining=n.
  - 10 with n words: if used < n, the pop is rejected. SP is unchanged, Underflow is set, and the unit stays in IDLE. Otherwise it goes to POP with remaining=n.
  - 11: SP <= Load_Value in one cycle. Flags and state are unchanged.
- PUSH, each unstalled cycle:
  - Mem_Valid=1, Mem_Write=1, Mem_Addr=SP.
  - At the edge: SP <= SP-1, remaining decrements.
  - When remaining is 1, next state is IDLE and Done <= 1.
- POP, each unstalled cycle:
  - Mem_Valid=1, Mem_Write=0, Mem_Addr=SP+1.
  - At the edge: SP <= SP+1, remaining decrements.
  - When remaining is 1, next state is IDLE and Done <= 1.
- In IDLE: Mem_Addr=SP, Mem_Valid=0, Mem_Write=0.
- Busy = (state != IDLE). Change_SP is ignored while Busy.
- Stall=1 freezes all registers (SP, state, remaining, flags) and forces Mem_Valid=0. Done is cleared during stall.
- Overflow and Underflow are cleared only by Rst.

## Timing
- Reset values:
  - Output_Signal = SP_RESET, Mem_Addr = SP_RESET.
  - Mem_Valid, Mem_Write, Busy, Done, Overflow, Underflow all 0.
  - State = IDLE.
- Rst has priority over Stall and over any operation, including mid-burst. An aborted burst leaves SP = SP_RESET and no further Mem_Valid.
- Burst latency: request accepted at edge 0; words are presented in cycles 1..n (plus stall cycles); Done is high in cycle n+1; a new request is accepted at edge n+1.
- Output_Signal and Busy are registered-state outputs. Mem_Addr, Mem_Valid and Mem_Write are combinational from state, SP and Stall.
- A rejected push or pop sets its flag visibly in the next cycle. No Mem_Valid is produced and Done stays 0.
- Load is visible on Output_Signal one cycle after the request.

## Configuration
- SP_BOUNDS_CHECK_EN defined: overflow and underflow checks active as described above.
- SP_BOUNDS_CHECK_EN undefined:
  - No checks are made. Every push and pop is accepted.
  - SP wraps modulo 2^WIDTH.
  - Overflow and Underflow are tied to 0.

## Test plan
- Reset and push, with Rst high for 2 cycles and then a push of 1 word: Output_Signal = 000FFFFF; Mem_Valid for 1 cycle with Mem_Addr=000FFFFF and Mem_Write=1; then SP = 000FFFFE and Done pulses.
- Push of 2 words, then pop of 2 words:
  - Push addresses FFFFF then FFFFE.
  - Pop addresses FFFFE then FFFFF, with Mem_Write=0.
  - SP returns to 000FFFFF; Busy is high for 2 cycles per burst.
- Underflow: pop of 1 word on an empty stack -> Underflow=1, SP unchanged, no Mem_Valid; the flag persists until Rst.
- Overflow, with DEPTH=4: push 3 words, then push 2 -> second push is rejected, Overflow=1, SP = 000FFFFC. In a build without SP_BOUNDS_CHECK_EN both pushes are accepted and SP = 000FFFFA.
- Stall mid-burst: a 3-word push with Stall high for 2 cycles after word 1 -> Mem_Valid drops for 2 cycles, then words 2 and 3 are presented at FFFFE and FFFFD, and Done is delayed by 2 cycles.
- Load and reset mid-operation:
  - Load 00000100 -> Output_Signal = 00000100 next cycle.
  - Then, during a 2-word push, Rst high in cycle 1 -> SP = 000FFFFF, Busy=0, no second word presented.

Source files
------------

// File: rtl/stack_pointer_unit.sv
// Stack pointer with multi-word push/pop bursts (one word per cycle), load, and optional bounds flags.
// Optional feature: define SP_BOUNDS_CHECK_EN to enable overflow/underflow rejection and sticky flags.
module stack_pointer_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(32'h000FFFFF),
    parameter int               DEPTH    = 1024,
    parameter int               CNT_W    = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Change_SP,
    input  logic [1:0]       Control_Mux,
    input  logic [CNT_W-1:0] Word_Count,
    input  logic [WIDTH-1:0] Load_Value,
    input  logic             Stall,
    output logic [WIDTH-1:0] Output_Signal,
    output logic [WIDTH-1:0] Mem_Addr,
    output logic             Mem_Valid,
    output logic             Mem_Write,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow,
    output logic             Underflow
);

    typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] n_words;
    logic             req;
    logic             push_rej, pop_rej;

    assign n_words = (Word_Count == '0) ? CNT_W'(1) : Word_Count;
    assign req     = (state_q == S_IDLE) && Change_SP && !Stall;

`ifdef SP_BOUNDS_CHECK_EN
    logic [WIDTH-1:0] used;
    logic [WIDTH:0]   push_need;
    logic             ovf_q, udf_q;

    // Extra bit keeps used+n from wrapping before the capacity compare.
    assign used      = SP_RESET - sp_q;
    assign push_need = {1'b0, used} + (WIDTH+1)'(n_words);
    assign push_rej  = push_need > (WIDTH+1)'(DEPTH);
    assign pop_rej   = used < WIDTH'(n_words);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (req && (Control_Mux == 2'b01) && push_rej) ovf_q <= 1'b1;
            if (req && (Control_Mux == 2'b10) && pop_rej)  udf_q <= 1'b1;
        end
    end

    assign Overflow  = ovf_q;
    assign Underflow = udf_q;
`else
    assign push_rej  = 1'b0;
    assign pop_rej   = 1'b0;
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            sp_q    <= SP_RESET;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Stall holds everything but drops Done, so the pulse never stretches.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (!Stall) begin
            case (state_q)
                S_IDLE: begin
                    if (Change_SP) begin
                        case (Control_Mux)
                            2'b01: if (!push_rej) begin
                                state_d = S_PUSH;
                                rem_d   = n_words;
                            end
                            2'b10: if (!pop_rej) begin
                                state_d = S_POP;
                                rem_d   = n_words;
                            end
                            2'b11: sp_d = Load_Value;
                            default: ;
                        endcase
                    end
                end
                S_PUSH: begin
                    sp_d  = sp_q - WIDTH'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                S_POP: begin
                    sp_d  = sp_q + WIDTH'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pop reads the word just above SP; push writes at SP.
    assign Mem_Addr      = (state_q == S_POP) ? (sp_q + WIDTH'(1)) : sp_q;
    assign Busy          = (state_q != S_IDLE);
    assign Mem_Valid     = Busy && !Stall;
    assign Mem_Write     = (state_q == S_PUSH) && !Stall;
    assign Output_Signal = sp_q;
    assign Done          = done_q;

endmodule
